d7s_scan_capture: RTL



---
 rtl/d7s_pkg.sv | 41 ++++
 rtl/d7s_scan_capture_if.sv | 33 +++
 rtl/d7s_seg_decode.sv | 41 ++++
 rtl/d7s_scan_capture.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/d7s_pkg.sv
// d7s_pkg: shared definitions for the 7-segment scan-capture block.
//   - SEG_W / NUM_DIG: segment bus width and digits per frame (= select width)
//   - SEG_0..SEG_F, SEG_BLANK: segment patterns {g,f,e,d,c,b,a}, active-high
//   - d7s_scan_t: registered {sel, seg} pin sample
//   - d7s_frame_t: one assembled frame {nibbles[2:0], blank[2:0], err}
package d7s_pkg;

    localparam int SEG_W   = 7;
    localparam int NUM_DIG = 3;
    localparam int NIB_W   = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic [NUM_DIG-1:0] sel;
        logic [SEG_W-1:0]   seg;
    } d7s_scan_t;

    typedef struct packed {
        logic [NUM_DIG-1:0][NIB_W-1:0] nibbles;
        logic [NUM_DIG-1:0]            blank;
        logic                          err;
    } d7s_frame_t;

endpackage

// File: rtl/d7s_scan_capture_if.sv
// d7s_scan_capture_if: frame output channel (valid/ready).
//   frame_data  : {d2,d1,d0} nibbles
//   frame_blank : per-digit all-segments-off flag
//   frame_err   : some digit in the frame was undecodable
//   frame_valid : frame available (producer)
//   frame_ready : consumer accepts
// master = frame producer (the capture block), slave = consumer.
interface d7s_scan_capture_if;
    import d7s_pkg::*;

    logic [NUM_DIG*NIB_W-1:0] frame_data;
    logic [NUM_DIG-1:0]       frame_blank;
    logic                     frame_err;
    logic                     frame_valid;
    logic                     frame_ready;

    modport master (
        output frame_data,
        output frame_blank,
        output frame_err,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_blank,
        input  frame_err,
        input  frame_valid,
        output frame_ready
    );

endinterface

// File: rtl/d7s_seg_decode.sv
// d7s_seg_decode: combinational 7-segment pattern to hex nibble decoder.
//   i_seg    : segment pattern {g,f,e,d,c,b,a}
//   o_nibble : decoded value (0 when blank or undecodable)
//   o_blank  : all segments off
//   o_err    : pattern is neither a hex glyph nor blank (exact match only)
module d7s_seg_decode
    import d7s_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output logic [NIB_W-1:0] o_nibble,
    output logic             o_blank,
    output logic             o_err
);

    always_comb begin
        o_nibble = 4'h0;
        o_blank  = 1'b0;
        o_err    = 1'b0;
        case (i_seg)
            SEG_0:     o_nibble = 4'h0;
            SEG_1:     o_nibble = 4'h1;
            SEG_2:     o_nibble = 4'h2;
            SEG_3:     o_nibble = 4'h3;
            SEG_4:     o_nibble = 4'h4;
            SEG_5:     o_nibble = 4'h5;
            SEG_6:     o_nibble = 4'h6;
            SEG_7:     o_nibble = 4'h7;
            SEG_8:     o_nibble = 4'h8;
            SEG_9:     o_nibble = 4'h9;
            SEG_A:     o_nibble = 4'hA;
            SEG_B:     o_nibble = 4'hB;
            SEG_C:     o_nibble = 4'hC;
            SEG_D:     o_nibble = 4'hD;
            SEG_E:     o_nibble = 4'hE;
            SEG_F:     o_nibble = 4'hF;
            SEG_BLANK: o_blank  = 1'b1;
            default:   o_err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/d7s_scan_capture.sv
// d7s_scan_capture: receive side of a multiplexed 7-segment display.
// Samples the segment bus and one-hot digit selects, captures each digit
// once per sufficiently long dwell, decodes it, and hands out complete
// 3-digit frames over a valid/ready channel.
//   clk      : system clock, rising edge
//   rst_n    : synchronous active-low reset
//   seg_in   : segment bus {g,f,e,d,c,b,a}, active-high
//   sel_in   : digit select, one-hot, bit0 = least significant digit
//   frame_if : frame output channel (master side)
//   overrun  : sticky, a completed frame was dropped because the slot was full
module d7s_scan_capture
    import d7s_pkg::*;
#(
    parameter  int STABLE_CYC = 4,
    localparam int CNT_W      = $clog2(STABLE_CYC + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEG_W-1:0]    seg_in,
    input  logic [NUM_DIG-1:0]  sel_in,
    d7s_scan_capture_if.master  frame_if,
    output logic                overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

    d7s_scan_t                       w_in;
    d7s_scan_t                       r_s;
    logic [CNT_W-1:0]                r_cnt;
    logic                            r_was_max;

    logic [NUM_DIG-1:0]              r_mask;
    logic [NUM_DIG-1:0][NIB_W-1:0]   r_dig_nib;
    logic [NUM_DIG-1:0]              r_dig_blk;
    logic [NUM_DIG-1:0]              r_dig_err;
    d7s_frame_t                      r_frame;
    logic                            r_valid;
    logic                            r_overrun;

    logic [NIB_W-1:0]                w_nib;
    logic                            w_blank;
    logic                            w_err;
    logic                            w_capture;
    logic                            w_resync;
    logic                            w_complete;
    logic                            w_slot_free;
    logic [NUM_DIG-1:0]              w_hit;
    logic [NUM_DIG-1:0]              w_mask_next;
    logic [NUM_DIG-1:0][NIB_W-1:0]   w_next_nib;
    logic [NUM_DIG-1:0]              w_next_blk;
    logic [NUM_DIG-1:0]              w_next_err;

    assign w_in = '{sel: sel_in, seg: seg_in};

    // The counter compares the incoming sample with the one already held,
    // so r_cnt counts how many times s_reg has repeated. Non-one-hot
    // selects (blanking gaps, overlap glitches) never accumulate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s       <= '0;
            r_cnt     <= '0;
            r_was_max <= 1'b0;
        end else begin
            r_s       <= w_in;
            r_was_max <= (r_cnt == CNT_MAX);
            if (!$onehot(w_in.sel) || (w_in != r_s)) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Fires only on the first cycle of saturation: one capture per dwell.
    assign w_capture = (r_cnt == CNT_MAX) && !r_was_max;

    d7s_seg_decode u_dec (
        .i_seg    (r_s.seg),
        .o_nibble (w_nib),
        .o_blank  (w_blank),
        .o_err    (w_err)
    );

    // Seeing a digit twice before the frame closes means we lost alignment
    // with the scan; restart the frame from that digit.
    assign w_resync = |(r_mask & r_s.sel);

    always_comb begin
        w_mask_next = r_mask;
        if (w_capture) begin
            w_mask_next = w_resync ? r_s.sel : (r_mask | r_s.sel);
        end
    end

    assign w_complete  = w_capture && (w_mask_next == {NUM_DIG{1'b1}});
    assign w_slot_free = !r_valid || frame_if.frame_ready;

    // Digits outside the mask may hold stale values after a resync; they are
    // never used because a frame only completes once every digit has been
    // recaptured.
    generate
        for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_dig
            assign w_hit[gi]      = w_capture && r_s.sel[gi];
            assign w_next_nib[gi] = w_hit[gi] ? w_nib   : r_dig_nib[gi];
            assign w_next_blk[gi] = w_hit[gi] ? w_blank : r_dig_blk[gi];
            assign w_next_err[gi] = w_hit[gi] ? w_err   : r_dig_err[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask    <= '0;
            r_dig_nib <= '0;
            r_dig_blk <= '0;
            r_dig_err <= '0;
            r_frame   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_mask    <= w_complete ? '0 : w_mask_next;
            r_dig_nib <= w_next_nib;
            r_dig_blk <= w_next_blk;
            r_dig_err <= w_next_err;
            if (w_complete && w_slot_free) begin
                // Covers the back-to-back case: transfer and reload on one edge.
                r_frame.nibbles <= w_next_nib;
                r_frame.blank   <= w_next_blk;
                r_frame.err     <= |w_next_err;
                r_valid         <= 1'b1;
            end else begin
                if (w_complete) begin
                    r_overrun <= 1'b1;
                end
                if (r_valid && frame_if.frame_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign frame_if.frame_data  = r_frame.nibbles;
    assign frame_if.frame_blank = r_frame.blank;
    assign frame_if.frame_err   = r_frame.err;
    assign frame_if.frame_valid = r_valid;
    assign overrun              = r_overrun;

endmodule
